paula_audio_mix_sched: RTL

- Time-multiplexed 4-channel Paula audio mixer and scheduler.
- Shares one signed-by-unsigned volume multiplier across the four channels using a 16-tick frame on clk7_en.
- Produces left/right 15-bit signed sums (ldatasum/rdatasum) that feed the stereo sigma-delta modulator.
- Output updates once per frame, matching the modulator's 16x linear-interpolation period.

---
 rtl/paula_audio_mix_sched.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/paula_audio_mix_sched.sv
// Paula audio mixer/scheduler: four channels share one signed-by-unsigned
// volume multiplier over a 16-tick frame advanced by clk7_en. Left/right
// sums are registered once per frame for the sigma-delta modulator.
module paula_audio_mix_sched #(
  parameter int         SW       = 8,
  parameter int         VW       = 7,
  parameter int         OW       = 15,
  parameter logic [3:0] LEFT_MAP = 4'b1001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk7_en,
  input  logic signed [SW-1:0] aud0,
  input  logic signed [SW-1:0] aud1,
  input  logic signed [SW-1:0] aud2,
  input  logic signed [SW-1:0] aud3,
  input  logic        [VW-1:0] vol0,
  input  logic        [VW-1:0] vol1,
  input  logic        [VW-1:0] vol2,
  input  logic        [VW-1:0] vol3,
  input  logic        [3:0]    mute,
  output logic signed [OW-1:0] ldatasum,
  output logic signed [OW-1:0] rdatasum,
  output logic                 sum_stb,
  output logic                 frame_sync
);

  // Product width; the product always fits (full scale is 2^(VW-1)).
  localparam int PW = SW + VW;
  // One guard bit so a saturating add can detect overflow.
  localparam int AW = OW + 1;
  localparam logic signed [AW-1:0] SAT_MAX = {2'b00, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {2'b11, {(OW-1){1'b0}}};
  // A set top volume bit means full scale, which is exactly that bit alone.
  localparam logic [VW-1:0] FULL_VOL = {1'b1, {(VW-1){1'b0}}};

  logic        [3:0]    fc_reg, fc_next;
  logic signed [SW-1:0] aud_in       [4];
  logic        [VW-1:0] vol_in       [4];
  logic signed [SW-1:0] snap_aud_reg [4];
  logic        [VW-1:0] snap_vol_reg [4];
  logic        [3:0]    snap_mute_reg;
  logic        [VW-1:0] effvol       [4];
  logic        [1:0]    mul_sel, acc_sel;
  logic signed [PW-1:0] mul_a, mul_b, prod_full;
  logic signed [PW-1:0] prod_reg, prod_next;
  logic signed [OW-1:0] acc_l_reg, acc_l_next, acc_r_reg, acc_r_next;
  logic signed [OW-1:0] ldatasum_reg, ldatasum_next, rdatasum_reg, rdatasum_next;
  logic                 sum_stb_reg, sum_stb_next, frame_sync_reg, frame_sync_next;

  assign aud_in[0] = aud0;
  assign aud_in[1] = aud1;
  assign aud_in[2] = aud2;
  assign aud_in[3] = aud3;
  assign vol_in[0] = vol0;
  assign vol_in[1] = vol1;
  assign vol_in[2] = vol2;
  assign vol_in[3] = vol3;

  // Effective volume per channel from the frame snapshot: mute forces 0,
  // the top bit clamps to full scale, otherwise the low bits are used.
  for (genvar gi = 0; gi < 4; gi++) begin : g_effvol
    assign effvol[gi] = snap_mute_reg[gi]        ? '0 :
                        snap_vol_reg[gi][VW-1]   ? FULL_VOL :
                        {1'b0, snap_vol_reg[gi][VW-2:0]};
  end

  // fc=1..4 multiplies channel fc-1; fc=2..5 accumulates channel fc-2.
  assign mul_sel = fc_reg[1:0] - 2'd1;
  assign acc_sel = fc_reg[1:0] - 2'd2;

  // Shared multiplier: signed sample times zero-extended (non-negative) volume.
  assign mul_a     = PW'(snap_aud_reg[mul_sel]);
  assign mul_b     = PW'({1'b0, effvol[mul_sel]});
  assign prod_full = mul_a * mul_b;

  // Add a product into an accumulator, clamping instead of wrapping.
  function automatic logic signed [OW-1:0] sat_add(input logic signed [OW-1:0] a,
                                                   input logic signed [PW-1:0] b);
    logic signed [AW-1:0] s;
    s = AW'(a) + AW'(b);
    if (s > SAT_MAX) return SAT_MAX[OW-1:0];
    if (s < SAT_MIN) return SAT_MIN[OW-1:0];
    return s[OW-1:0];
  endfunction

  // Input snapshot taken at the fc=0 tick; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        snap_aud_reg[i] <= '0;
        snap_vol_reg[i] <= '0;
      end
      snap_mute_reg <= '0;
    end else if (clk7_en && fc_reg == 4'd0) begin
      for (int i = 0; i < 4; i++) begin
        snap_aud_reg[i] <= aud_in[i];
        snap_vol_reg[i] <= vol_in[i];
      end
      snap_mute_reg <= mute;
    end
  end

  // Frame schedule: next-state for counter, product, accumulators, outputs.
  always_comb begin
    fc_next         = fc_reg;
    prod_next       = prod_reg;
    acc_l_next      = acc_l_reg;
    acc_r_next      = acc_r_reg;
    ldatasum_next   = ldatasum_reg;
    rdatasum_next   = rdatasum_reg;
    sum_stb_next    = 1'b0;
    frame_sync_next = 1'b0;
    if (clk7_en) begin
      fc_next = fc_reg + 4'd1;
      if (fc_reg == 4'd0) begin
        acc_l_next      = '0;
        acc_r_next      = '0;
        frame_sync_next = 1'b1;
      end
      if (fc_reg >= 4'd1 && fc_reg <= 4'd4) begin
        prod_next = prod_full;
      end
      if (fc_reg >= 4'd2 && fc_reg <= 4'd5) begin
        if (LEFT_MAP[acc_sel]) acc_l_next = sat_add(acc_l_reg, prod_reg);
        else                   acc_r_next = sat_add(acc_r_reg, prod_reg);
      end
      if (fc_reg == 4'd15) begin
        ldatasum_next = acc_l_reg;
        rdatasum_next = acc_r_reg;
        sum_stb_next  = 1'b1;
      end
    end
  end

  // State registers; reset abandons the current frame and clears outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      fc_reg         <= '0;
      prod_reg       <= '0;
      acc_l_reg      <= '0;
      acc_r_reg      <= '0;
      ldatasum_reg   <= '0;
      rdatasum_reg   <= '0;
      sum_stb_reg    <= 1'b0;
      frame_sync_reg <= 1'b0;
    end else begin
      fc_reg         <= fc_next;
      prod_reg       <= prod_next;
      acc_l_reg      <= acc_l_next;
      acc_r_reg      <= acc_r_next;
      ldatasum_reg   <= ldatasum_next;
      rdatasum_reg   <= rdatasum_next;
      sum_stb_reg    <= sum_stb_next;
      frame_sync_reg <= frame_sync_next;
    end
  end

  assign ldatasum   = ldatasum_reg;
  assign rdatasum   = rdatasum_reg;
  assign sum_stb    = sum_stb_reg;
  assign frame_sync = frame_sync_reg;

endmodule
